// File: rtl/ooo_resp_pkg.sv
// ooo_resp_pkg: shared types, sizes and helpers for the out-of-order read
// responder.
//   - entry_state_e : per-ID entry life cycle (FREE -> WAIT -> READY -> FREE)
//   - r_state_e     : R channel output FSM states
//   - find_first_ready : rotating first-READY search over the 16 entries
package ooo_resp_pkg;

    localparam int ID_W    = 4;
    localparam int NUM_IDS = 16;
    localparam int DLY_W   = 5;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting
    // register (bit 15 is the oldest bit).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } entry_state_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } r_state_e;

    // Returns {found, index} of the first set bit of ready_mask, searching
    // upward from start and wrapping modulo NUM_IDS.
    function automatic logic [ID_W:0] find_first_ready(
        input logic [NUM_IDS-1:0] ready_mask,
        input logic [ID_W-1:0]    start
    );
        logic            found;
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] pick;
        found = 1'b0;
        pick  = {ID_W{1'b0}};
        for (int i = 0; i < NUM_IDS; i++) begin
            idx = start + ID_W'(i);
            if (!found && ready_mask[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return {found, pick};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, polynomial
// x^16 + x^14 + x^13 + x^11 + 1. Advances every clock.
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset (loads SEED)
//   state_o out  current 16-bit LFSR state
// SEED must be nonzero, otherwise the register locks up at zero.
module lfsr16
    import ooo_resp_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state_o
);

    logic feedback_s;

    assign feedback_s = ^(state_o & LFSR_TAPS);

    // Shift register with XOR feedback into bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_o <= SEED;
        end else begin
            state_o <= {state_o[14:0], feedback_s};
        end
    end

endmodule

// File: rtl/ooo_read_responder.sv
// ooo_read_responder: synthesizable AR/R read-channel slave model that
// returns responses out of acceptance order with pseudo-random latency.
// At most one request per ID is outstanding.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_arid_i        AR request ID (4 bits)
//   s_arvalid_i     AR valid
//   s_arready_o     AR ready (combinational: entry[s_arid_i] is FREE)
//   s_rdata_o       R data, zero-extended {id, seq tag}
//   s_rid_o         R ID
//   s_rvalid_o      R valid
//   s_rready_i      R ready
//   outstanding_o   number of non-FREE entries (0..16)
//
// Optional build macro RESP_IN_ORDER_EN: when defined, a 16-deep ID FIFO
// records acceptance order and responses leave strictly in that order;
// the rotate pointer is not built. When undefined, the R FSM picks the
// first READY entry searching upward from a rotate pointer that is
// reloaded from the LFSR on every R handshake.
module ooo_read_responder
    import ooo_resp_pkg::*;
#(
    parameter int          DATA_WIDTH  = 8,
    parameter int          MIN_LATENCY = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            s_arid_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [3:0]            s_rid_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    output logic [4:0]            outstanding_o
);

    entry_state_e    entry_state_r [NUM_IDS];
    logic [DLY_W-1:0] entry_dly_r  [NUM_IDS];
    logic [ID_W-1:0] entry_tag_r   [NUM_IDS];

    r_state_e        r_state_r;
    logic [ID_W-1:0] seq_r;
    logic [15:0]     lfsr_s;
    logic            ar_fire_s;
    logic            r_fire_s;
    logic [DLY_W-1:0] new_dly_s;
    logic            pick_valid_s;
    logic [ID_W-1:0] pick_id_s;
    logic            unused_lfsr_s;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr_s)
    );

    assign unused_lfsr_s = ^lfsr_s[15:4];

    // arready looks only at the registered entry state, so an ID freed by
    // an R handshake becomes acceptable one cycle later.
    assign s_arready_o = (entry_state_r[s_arid_i] == FREE);
    assign ar_fire_s   = s_arvalid_i && s_arready_o;
    assign r_fire_s    = (r_state_r == SEND) && s_rready_i;
    assign new_dly_s   = DLY_W'(MIN_LATENCY) + {{(DLY_W-3){1'b0}}, lfsr_s[2:0]};

`ifdef RESP_IN_ORDER_EN
    logic [ID_W-1:0] fifo_mem_r [NUM_IDS];
    logic [ID_W-1:0] fifo_wr_r;
    logic [ID_W-1:0] fifo_rd_r;

    // Acceptance-order FIFO; occupancy always equals outstanding_o, so
    // outstanding_o doubles as the empty flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_r <= {ID_W{1'b0}};
            fifo_rd_r <= {ID_W{1'b0}};
            for (int i = 0; i < NUM_IDS; i++) begin
                fifo_mem_r[i] <= {ID_W{1'b0}};
            end
        end else begin
            if (ar_fire_s) begin
                fifo_mem_r[fifo_wr_r] <= s_arid_i;
                fifo_wr_r             <= fifo_wr_r + 4'd1;
            end
            if (r_fire_s) begin
                fifo_rd_r <= fifo_rd_r + 4'd1;
            end
        end
    end

    // Only the FIFO head may be issued, and only once it is READY.
    always_comb begin
        pick_id_s    = fifo_mem_r[fifo_rd_r];
        pick_valid_s = 1'b0;
        if ((outstanding_o != 5'd0) && (entry_state_r[fifo_mem_r[fifo_rd_r]] == READY)) begin
            pick_valid_s = 1'b1;
        end else begin
            pick_valid_s = 1'b0;
        end
    end
`else
    logic [NUM_IDS-1:0] ready_mask_s;
    logic [ID_W-1:0]    rot_ptr_r;

    // Rotating first-READY search starting at the rotate pointer.
    always_comb begin
        ready_mask_s = {NUM_IDS{1'b0}};
        for (int i = 0; i < NUM_IDS; i++) begin
            ready_mask_s[i] = (entry_state_r[i] == READY);
        end
        {pick_valid_s, pick_id_s} = find_first_ready(ready_mask_s, rot_ptr_r);
    end

    // Rotate pointer reseeded from the LFSR on every R handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rot_ptr_r <= {ID_W{1'b0}};
        end else if (r_fire_s) begin
            rot_ptr_r <= lfsr_s[3:0];
        end
    end
`endif

    // Entry table: accept moves FREE->WAIT, delay countdown moves
    // WAIT->READY, R handshake moves READY->FREE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                entry_state_r[i] <= FREE;
                entry_dly_r[i]   <= {DLY_W{1'b0}};
                entry_tag_r[i]   <= {ID_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_IDS; i++) begin
                if (ar_fire_s && (s_arid_i == ID_W'(i))) begin
                    entry_state_r[i] <= WAIT;
                    entry_dly_r[i]   <= new_dly_s;
                    entry_tag_r[i]   <= seq_r;
                end else if (r_fire_s && (s_rid_o == ID_W'(i))) begin
                    entry_state_r[i] <= FREE;
                end else if (entry_state_r[i] == WAIT) begin
                    if (entry_dly_r[i] <= 5'd1) begin
                        entry_state_r[i] <= READY;
                    end else begin
                        entry_dly_r[i] <= entry_dly_r[i] - 5'd1;
                    end
                end
            end
        end
    end

    // Sequence tag counter (wraps 15->0) and outstanding count.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_r         <= {ID_W{1'b0}};
            outstanding_o <= 5'd0;
        end else begin
            if (ar_fire_s) begin
                seq_r <= seq_r + 4'd1;
            end
            case ({ar_fire_s, r_fire_s})
                2'b10:   outstanding_o <= outstanding_o + 5'd1;
                2'b01:   outstanding_o <= outstanding_o - 5'd1;
                default: outstanding_o <= outstanding_o;
            endcase
        end
    end

    // R output FSM with registered beat outputs; IDLE always separates
    // two beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_r  <= IDLE;
            s_rvalid_o <= 1'b0;
            s_rid_o    <= 4'd0;
            s_rdata_o  <= {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        s_rid_o    <= pick_id_s;
                        s_rdata_o  <= DATA_WIDTH'({pick_id_s, entry_tag_r[pick_id_s]});
                        s_rvalid_o <= 1'b1;
                        r_state_r  <= SEND;
                    end
                end
                SEND: begin
                    if (s_rready_i) begin
                        s_rvalid_o <= 1'b0;
                        r_state_r  <= IDLE;
                    end
                end
                default: begin
                    s_rvalid_o <= 1'b0;
                    r_state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ooo_read_responder.sv
// tb_ooo_read_responder: directed self-checking bench for ooo_read_responder
// (default parameters). Inputs change and outputs are sampled on the
// falling clock edge. Honours RESP_IN_ORDER_EN for the ordering check.
module tb_ooo_read_responder;

    logic       clk;
    logic       rst;
    logic [3:0] s_arid_i;
    logic       s_arvalid_i;
    logic       s_arready_o;
    logic [7:0] s_rdata_o;
    logic [3:0] s_rid_o;
    logic       s_rvalid_o;
    logic       s_rready_i;
    logic [4:0] outstanding_o;

    int n_cmp;
    int n_err;

    ooo_read_responder dut (
        .clk           (clk),
        .rst           (rst),
        .s_arid_i      (s_arid_i),
        .s_arvalid_i   (s_arvalid_i),
        .s_arready_o   (s_arready_o),
        .s_rdata_o     (s_rdata_o),
        .s_rid_o       (s_rid_o),
        .s_rvalid_o    (s_rvalid_o),
        .s_rready_i    (s_rready_i),
        .outstanding_o (outstanding_o)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        s_arvalid_i = 1'b0;
        s_arid_i    = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one AR and return on the falling edge just after its handshake.
    task automatic send_ar(input logic [3:0] id);
        int n;
        n           = 0;
        s_arid_i    = id;
        s_arvalid_i = 1'b1;
        #1;
        while (!s_arready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ar_accept_timeout", 32'(n < 100), 32'd1);
        @(negedge clk);
        s_arvalid_i = 1'b0;
    endtask

    task automatic wait_rvalid(input int limit, output int cyc);
        cyc = 0;
        while (!s_rvalid_o && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        chk("rvalid_timeout", 32'(s_rvalid_o), 32'd1);
    endtask

    initial begin
        int cyc;
        int cnt;
        int beats;
        logic [15:0] seen;
        logic        ordered;
        logic        dup;

        n_cmp       = 0;
        n_err       = 0;
        s_rready_i  = 1'b0;
        s_arvalid_i = 1'b0;
        s_arid_i    = 4'd0;
        rst         = 1'b0;
        @(negedge clk);

        // ---- Reset state, then 5 idle cycles ----
        do_reset();
        chk("rst_rvalid", 32'(s_rvalid_o), 32'd0);
        chk("rst_rid", 32'(s_rid_o), 32'd0);
        chk("rst_rdata", 32'(s_rdata_o), 32'd0);
        repeat (5) @(negedge clk);
        chk("idle_outstanding", 32'(outstanding_o), 32'd0);
        chk("idle_rvalid", 32'(s_rvalid_o), 32'd0);
        for (int i = 0; i < 16; i++) begin
            s_arid_i = 4'(i);
            #1;
            chk("idle_arready", 32'(s_arready_o), 32'd1);
        end

        // ---- Single request id 3 ----
        do_reset();
        s_rready_i = 1'b1;
        send_ar(4'h3);
        chk("single_out_1", 32'(outstanding_o), 32'd1);
        wait_rvalid(20, cyc);
        chk("single_latency", 32'((cyc >= 2) && (cyc <= 10)), 32'd1);
        chk("single_rid", 32'(s_rid_o), 32'h3);
        chk("single_rdata", 32'(s_rdata_o), 32'h30);
        @(negedge clk);
        chk("single_rvalid_drop", 32'(s_rvalid_o), 32'd0);
        chk("single_out_0", 32'(outstanding_o), 32'd0);
        beats = 0;
        for (int i = 0; i < 20; i++) begin
            if (s_rvalid_o) beats++;
            @(negedge clk);
        end
        chk("single_no_extra", 32'(beats), 32'd0);

        // ---- Same ID while pending ----
        do_reset();
        s_rready_i = 1'b0;
        send_ar(4'h5);
        s_arid_i    = 4'h5;
        s_arvalid_i = 1'b1;
        #1;
        chk("dup_arready_wait", 32'(s_arready_o), 32'd0);
        wait_rvalid(20, cyc);
        chk("dup_arready_send", 32'(s_arready_o), 32'd0);
        chk("dup_first_rdata", 32'(s_rdata_o), 32'h50);
        s_rready_i = 1'b1;
        @(negedge clk);
        chk("dup_freed_arready", 32'(s_arready_o), 32'd1);
        chk("dup_out_0", 32'(outstanding_o), 32'd0);
        @(negedge clk);
        s_arvalid_i = 1'b0;
        chk("dup_out_1", 32'(outstanding_o), 32'd1);
        wait_rvalid(20, cyc);
        chk("dup_second_rid", 32'(s_rid_o), 32'h5);
        chk("dup_second_rdata", 32'(s_rdata_o), 32'h51);
        @(negedge clk);

        // ---- Fill all 16 IDs, then drain ----
        do_reset();
        s_rready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_ar(4'(i));
        end
        chk("full_outstanding", 32'(outstanding_o), 32'd16);
        for (int i = 0; i < 16; i++) begin
            s_arid_i = 4'(i);
            #1;
            chk("full_arready", 32'(s_arready_o), 32'd0);
        end
        s_rready_i = 1'b1;
        cnt        = 0;
        cyc        = 0;
        seen       = 16'h0000;
        ordered    = 1'b1;
        dup        = 1'b0;
        while (cnt < 16 && cyc < 400) begin
            if (s_rvalid_o) begin
                chk("drain_rdata", 32'(s_rdata_o), 32'({s_rid_o, s_rid_o}));
                if (seen[s_rid_o]) dup = 1'b1;
                if (s_rid_o != 4'(cnt)) ordered = 1'b0;
                seen[s_rid_o] = 1'b1;
                cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("drain_count", 32'(cnt), 32'd16);
        chk("drain_all_ids", 32'(seen), 32'hFFFF);
        chk("drain_no_dup", 32'(dup), 32'd0);
`ifdef RESP_IN_ORDER_EN
        chk("drain_in_order", 32'(ordered), 32'd1);
`else
        chk("drain_reordered", 32'(ordered), 32'd0);
`endif
        @(negedge clk);
        chk("drain_out_0", 32'(outstanding_o), 32'd0);

        // ---- Backpressure: hold rready low for 12 cycles ----
        do_reset();
        s_rready_i = 1'b0;
        send_ar(4'h9);
        wait_rvalid(20, cyc);
        for (int i = 0; i < 12; i++) begin
            chk("stall_rvalid", 32'(s_rvalid_o), 32'd1);
            chk("stall_rid", 32'(s_rid_o), 32'h9);
            chk("stall_rdata", 32'(s_rdata_o), 32'h90);
            @(negedge clk);
        end
        s_rready_i = 1'b1;
        @(negedge clk);
        chk("stall_done", 32'(s_rvalid_o), 32'd0);
        chk("stall_out_0", 32'(outstanding_o), 32'd0);

        // ---- Reset with requests pending ----
        do_reset();
        s_rready_i = 1'b0;
        send_ar(4'h1);
        send_ar(4'h2);
        send_ar(4'h3);
        send_ar(4'h4);
        repeat (12) @(negedge clk);
        chk("pend_outstanding", 32'(outstanding_o), 32'd4);
        chk("pend_rvalid", 32'(s_rvalid_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_rvalid", 32'(s_rvalid_o), 32'd0);
        chk("midrst_outstanding", 32'(outstanding_o), 32'd0);
        s_rready_i = 1'b1;
        beats = 0;
        for (int i = 0; i < 50; i++) begin
            if (s_rvalid_o) beats++;
            @(negedge clk);
        end
        chk("midrst_no_stale", 32'(beats), 32'd0);
        for (int i = 1; i < 5; i++) begin
            s_arid_i = 4'(i);
            #1;
            chk("midrst_arready", 32'(s_arready_o), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
